// File: rtl/wide_add_seq.sv
// Multi-cycle 64-bit (WORDS x 16-bit) add/subtract sequencer driving an external
// combinational 16-bit adder one slice per cycle, least-significant slice first.
module wide_add_seq #(
    parameter int WORDS   = 4,
    parameter int SLICE_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [WORDS*SLICE_W-1:0] req_a,
    input  logic [WORDS*SLICE_W-1:0] req_b,
    input  logic                     req_sub,
    input  logic                     req_cin,
    output logic [SLICE_W-1:0]       add_a,
    output logic [SLICE_W-1:0]       add_b,
    output logic                     add_cin,
    input  logic [SLICE_W-1:0]       add_s,
    input  logic                     add_cout,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WORDS*SLICE_W-1:0] rsp_sum,
    output logic                     rsp_cout,
    output logic                     rsp_ovf
);

    localparam int         W      = WORDS * SLICE_W;
    localparam logic [2:0] K_LAST = 3'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] k;
    logic       carry;
    logic [W-1:0] a_reg;
    logic [W-1:0] b_reg;
    logic [W-1:0] sum_reg;
    logic       cout_reg;
    logic       ovf_reg;
    logic       last;

    assign last     = (k == K_LAST);
    assign rsp_sum  = sum_reg;
    assign rsp_cout = cout_reg;
    assign rsp_ovf  = ovf_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Adder inputs are steered only during RUN; elsewhere they rest at zero.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        case (state)
            IDLE: req_ready = !rst;
            RUN: begin
                add_cin = carry;
                for (int i = 0; i < WORDS; i++) begin
                    if (k == i[2:0]) begin
                        add_a = a_reg[i*SLICE_W +: SLICE_W];
                        add_b = b_reg[i*SLICE_W +: SLICE_W];
                    end
                end
            end
            DONE:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Subtract is A + ~B + 1: invert B once at acceptance and seed the carry with 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k        <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_reg <= req_a;
                        b_reg <= req_sub ? ~req_b : req_b;
                        carry <= req_sub | req_cin;
                        k     <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (k == i[2:0]) begin
                            sum_reg[i*SLICE_W +: SLICE_W] <= add_s;
                        end
                    end
                    carry <= add_cout;
                    k     <= k + 3'd1;
                    if (last) begin
                        cout_reg <= add_cout;
                        ovf_reg  <= (a_reg[W-1] == b_reg[W-1]) &&
                                    (add_s[SLICE_W-1] != a_reg[W-1]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wide_add_seq.sv
// Scoreboard bench for wide_add_seq with a behavioural 16-bit adder on the add_* port.
module tb_wide_add_seq;

    localparam int WORDS = 4;
    localparam int W     = WORDS * 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         req_sub;
    logic         req_cin;
    logic [15:0]  add_a;
    logic [15:0]  add_b;
    logic         add_cin;
    logic [15:0]  add_s;
    logic         add_cout;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;
    logic         rsp_ovf;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic [7:0]  cin_seq;
    logic [15:0] b_slice0;
    int   lat;

    always #5 clk = ~clk;

    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + 17'(add_cin);

    wide_add_seq #(.WORDS(WORDS), .SLICE_W(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .req_cin(req_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf)
    );

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic cin);
        exp_t       e;
        logic [W:0] full;
        if (sub) begin
            full   = {1'b0, a} - {1'b0, b};
            e.cout = (a >= b);
            e.sum  = full[W-1:0];
            e.ovf  = (a[W-1] != b[W-1]) && (e.sum[W-1] != a[W-1]);
        end else begin
            full   = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            e.cout = full[W];
            e.sum  = full[W-1:0];
            e.ovf  = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
        end
        return e;
    endfunction

    // Called at a negedge; returns at the first negedge after the acceptance edge.
    task automatic send_req(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sub, input logic cin);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_ready_before_send", W'(req_ready), W'(1));
        req_a     = a;
        req_b     = b;
        req_sub   = sub;
        req_cin   = cin;
        req_valid = 1'b1;
        sb.push_back(model(a, b, sub, cin));
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Records per-slice adder traffic and the edge count from acceptance to rsp_valid.
    task automatic wait_rsp();
        exp_t e;
        lat      = 0;
        cin_seq  = '0;
        b_slice0 = '0;
        while (!rsp_valid && lat < 20) begin
            if (lat < 8) cin_seq[lat] = add_cin;
            if (lat == 0) b_slice0 = add_b;
            @(negedge clk);
            lat++;
        end
        check_eq("latency", W'(lat), W'(WORDS));
        check_eq("add_a_idle_in_done", W'(add_a), W'(0));
        check_eq("req_ready_in_done", W'(req_ready), W'(0));
        check_eq("sb_depth", W'(sb.size()), W'(1));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("rsp_sum", rsp_sum, e.sum);
            check_eq("rsp_cout", W'(rsp_cout), W'(e.cout));
            check_eq("rsp_ovf", W'(rsp_ovf), W'(e.ovf));
        end
    endtask

    task automatic ack_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic cin);
        send_req(a, b, sub, cin);
        wait_rsp();
        ack_rsp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] held_sum;
        logic         held_cout;
        logic         held_ovf;
        logic         stable;
        logic         saw_valid;

        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0;
        req_sub = 1'b0; req_cin = 1'b0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_req_ready", W'(req_ready), W'(0));
        check_eq("rst_rsp_valid", W'(rsp_valid), W'(0));
        check_eq("rst_rsp_sum", rsp_sum, '0);
        check_eq("rst_add_a", W'(add_a), W'(0));
        rst = 1'b0;
        #1;
        check_eq("req_ready_after_rst", W'(req_ready), W'(1));
        @(negedge clk);

        // Carry chaining
        run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
        check_eq("chain_cin_seq", W'(cin_seq[3:0]), W'(4'b0010));

        // Full wrap
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);

        // Subtract with borrow
        run_op(64'h5, 64'h7, 1'b1, 1'b0);
        check_eq("sub_add_b_slice0", W'(b_slice0), W'(16'hFFF8));
        check_eq("sub_add_cin_slice0", W'(cin_seq[0]), W'(1));

        // Signed overflow
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);

        // Add with carry-in, and a subtract that ignores req_cin
        run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1);
        run_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b1);

        // Backpressure with a second request waiting
        send_req(64'hDEAD_BEEF_0000_1111, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
        wait_rsp();
        held_sum  = rsp_sum;
        held_cout = rsp_cout;
        held_ovf  = rsp_ovf;
        req_a = 64'h1111_2222_3333_4444; req_b = 64'h0000_0000_0000_0004;
        req_sub = 1'b1; req_cin = 1'b0; req_valid = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_sum !== held_sum || rsp_cout !== held_cout || rsp_ovf !== held_ovf ||
                rsp_valid !== 1'b1 || req_ready !== 1'b0)
                stable = 1'b0;
        end
        check_eq("bp_stable", W'(stable), W'(1));
        ack_rsp();
        check_eq("bp_req_ready_after_ack", W'(req_ready), W'(1));
        check_eq("bp_rsp_valid_after_ack", W'(rsp_valid), W'(0));
        check_eq("bp_sum_kept_after_ack", rsp_sum, held_sum);
        run_op(64'h1111_2222_3333_4444, 64'h0000_0000_0000_0004, 1'b1, 1'b0);

        // Reset mid-operation
        send_req(64'hFFFF_0000_FFFF_0000, 64'h0001_0001_0001_0001, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst_rsp_valid", W'(rsp_valid), W'(0));
        check_eq("midrst_req_ready", W'(req_ready), W'(0));
        check_eq("midrst_add_a", W'(add_a), W'(0));
        check_eq("midrst_add_cin", W'(add_cin), W'(0));
        check_eq("midrst_rsp_sum", rsp_sum, '0);
        check_eq("midrst_rsp_cout_ovf", W'({rsp_cout, rsp_ovf}), W'(0));
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("midrst_req_ready_after", W'(req_ready), W'(1));
        saw_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) saw_valid = 1'b1;
        end
        check_eq("midrst_no_rsp_pulse", W'(saw_valid), W'(0));
        run_op(64'h1234, 64'h1111, 1'b0, 1'b0);
        check_eq("midrst_next_sum", rsp_sum, 64'h2345);

        // A few random operations
        for (int i = 0; i < 6; i++) begin
            run_op({$urandom, $urandom}, {$urandom, $urandom},
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
